// File: rtl/edge_uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define EDGE_UART_RX_PARITY_EN to expect an even-parity bit between D7 and the stop bit.
module edge_uart_rx_fifo #(
    parameter int DIV       = 54,
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   overrun,
    output logic                   frame_err,
    output logic                   parity_err,
    input  logic                   clear_err,
    output logic                   rx_irq
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] IRQ_C   = (AW+1)'(IRQ_LEVEL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef EDGE_UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef EDGE_UART_RX_PARITY_EN
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  sc_q, sc_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        overrun_q, overrun_d, frame_q, frame_d, irq_q, irq_d;
`ifdef EDGE_UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d, perr_q, perr_d, par_set;
`endif

    logic        rxs, tick, sample, bit_end;
    logic        push, frame_set, pop, full, wr_en;
    logic [AW:0] count;

    assign rxs     = sync2_q;
    assign tick    = (div_q == DIV_M1);
    assign sample  = tick && (sc_q == 4'd7);
    assign bit_end = tick && (sc_q == 4'd15);

    // FSM: state register plus all other resettable flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            div_q     <= '0;
            sc_q      <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            irq_q     <= 1'b0;
`ifdef EDGE_UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_q     <= div_d;
            sc_q      <= sc_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            irq_q     <= irq_d;
`ifdef EDGE_UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Next-state; STOP returns to IDLE at mid-bit so a back-to-back start edge is caught
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!rxs) state_d = S_START;
            S_START: begin
                if (sample && rxs)  state_d = S_IDLE;
                else if (bit_end)   state_d = S_DATA;
            end
            S_DATA:   if (bit_end && bitcnt_q == 3'd7) state_d = S_AFTER_DATA;
`ifdef EDGE_UART_RX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:   if (sample) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef EDGE_UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        if (state_q == S_STOP && sample) begin
            if (!rxs) frame_set = 1'b1;
`ifdef EDGE_UART_RX_PARITY_EN
            else if (par_bad_q) par_set = 1'b1;
`endif
            else push = 1'b1;
        end
    end

    always_comb begin
        sync1_d  = rx;
        sync2_d  = sync1_q;
        div_d    = (state_q == S_IDLE || tick) ? 16'd0 : div_q + 16'd1;
        sc_d     = (state_q == S_IDLE) ? 4'd0 : (tick ? sc_q + 4'd1 : sc_q);
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        if (state_q == S_START) bitcnt_d = 3'd0;
        if (state_q == S_DATA) begin
            if (sample)  shift_d  = {rxs, shift_q[7:1]};
            if (bit_end) bitcnt_d = bitcnt_q + 3'd1;
        end
`ifdef EDGE_UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        if (state_q == S_START) par_bad_d = 1'b0;
        if (state_q == S_PARITY && sample) par_bad_d = ^{shift_q, rxs};
`endif
    end

    // FIFO; pointers carry one extra bit so full and empty are distinguishable
    always_comb begin
        count     = wr_q - rd_q;
        full      = (count == DEPTH_C);
        pop       = rx_valid && rx_ready;
        wr_en     = push && (!full || pop);
        wr_d      = wr_en ? wr_q + ONE_C : wr_q;
        rd_d      = pop ? rd_q + ONE_C : rd_q;
        mem_d     = mem_q;
        if (wr_en) mem_d[wr_q[AW-1:0]] = shift_q;
        overrun_d = (overrun_q && !clear_err) || (push && full && !pop);
        frame_d   = (frame_q && !clear_err) || frame_set;
        irq_d     = (count >= IRQ_C);
`ifdef EDGE_UART_RX_PARITY_EN
        perr_d    = (perr_q && !clear_err) || par_set;
`endif
    end

    assign rx_valid  = (count != '0);
    assign rx_data   = rx_valid ? mem_q[rd_q[AW-1:0]] : 8'h00;
    assign rx_count  = count;
    assign overrun   = overrun_q;
    assign frame_err = frame_q;
    assign rx_irq    = irq_q;
`ifdef EDGE_UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_edge_uart_rx_fifo.sv
// Directed bench for edge_uart_rx_fifo: table of frames with expected FIFO/flag state,
// plus hand-written glitch, drain, reset-mid-frame and parity sequences.
module tb_edge_uart_rx_fifo;
    localparam int DIV       = 4;
    localparam int DEPTH     = 4;
    localparam int IRQ_LEVEL = 2;
    localparam int BIT       = 16 * DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       overrun, frame_err, parity_err, rx_irq;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    edge_uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err),
        .clear_err(clear_err), .rx_irq(rx_irq)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       drain_before;
        logic       clr_before;
        int         idle_after;
        logic [2:0] exp_count;
        logic       exp_irq;
        logic       exp_ovr;
        logic       exp_ferr;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clock);
    endtask

    // flip_par inverts the even-parity bit when the parity build is used
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic flip_par);
        logic p;
        p = (^b) ^ flip_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef EDGE_UART_RX_PARITY_EN
        send_bit(p);
`endif
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
    endtask

    initial begin
        //          data   stop drn clr idle cnt irq ovr ferr head
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0,   3'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 100, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 0,   3'd1, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 1'b0, 0,   3'd2, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[4] = '{8'h03, 1'b1, 1'b0, 1'b0, 0,   3'd3, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{8'h04, 1'b1, 1'b0, 1'b0, 0,   3'd4, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[6] = '{8'h05, 1'b1, 1'b0, 1'b0, 0,   3'd4, 1'b1, 1'b1, 1'b0, 8'h01};

        repeat (5) @(negedge clock);
        chk("rst_data",  rx_data,    8'h00);
        chk("rst_valid", rx_valid,   1'b0);
        chk("rst_count", rx_count,   3'd0);
        chk("rst_ovr",   overrun,    1'b0);
        chk("rst_ferr",  frame_err,  1'b0);
        chk("rst_perr",  parity_err, 1'b0);
        chk("rst_irq",   rx_irq,     1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].drain_before) drain();
            if (vecs[v].clr_before) begin
                pulse_clear();
                chk($sformatf("v%0d_clr_ferr", v), frame_err, 1'b0);
            end
            send_frame(vecs[v].data, vecs[v].stop_v, 1'b0);
            repeat (vecs[v].idle_after) @(negedge clock);
            chk($sformatf("v%0d_count", v), rx_count, vecs[v].exp_count);
            chk($sformatf("v%0d_valid", v), rx_valid, vecs[v].exp_count != 3'd0);
            chk($sformatf("v%0d_irq", v),   rx_irq,   vecs[v].exp_irq);
            chk($sformatf("v%0d_ovr", v),   overrun,  vecs[v].exp_ovr);
            chk($sformatf("v%0d_ferr", v),  frame_err, vecs[v].exp_ferr);
            chk($sformatf("v%0d_perr", v),  parity_err, 1'b0);
            if (vecs[v].exp_count != 3'd0)
                chk($sformatf("v%0d_head", v), rx_data, vecs[v].exp_head);
        end

        // Drain the full FIFO: bytes 1..4 in order, the dropped 5th never appears
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), rx_valid, 1'b1);
            chk($sformatf("drain%0d_data", i),  rx_data,  8'(i + 1));
            @(negedge clock);
        end
        chk("drain_empty", rx_valid, 1'b0);
        chk("drain_count", rx_count, 3'd0);
        @(negedge clock);
        chk("drain_irq", rx_irq, 1'b0);
        rx_ready = 1'b0;

        pulse_clear();
        chk("clr_ovr", overrun, 1'b0);

        // Short low glitch must be rejected as a false start
        rx = 1'b0;
        repeat (6) @(negedge clock);
        rx = 1'b1;
        repeat (100) @(negedge clock);
        chk("glitch_count", rx_count, 3'd0);
        chk("glitch_ferr",  frame_err, 1'b0);
        chk("glitch_ovr",   overrun,   1'b0);

        // Reset during bit 4 of a frame, with a byte already buffered
        send_frame(8'h11, 1'b1, 1'b0);
        chk("pre_rst_count", rx_count, 3'd1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h96 >> i));
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rx = 1'b1;
        repeat (100) @(negedge clock);
        chk("mid_rst_count", rx_count, 3'd0);
        chk("mid_rst_valid", rx_valid, 1'b0);
        chk("mid_rst_ferr",  frame_err, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (200) @(negedge clock);
        chk("post_rst_count", rx_count, 3'd1);
        chk("post_rst_data",  rx_data,  8'h5A);
        chk("post_rst_ferr",  frame_err, 1'b0);
        chk("post_rst_ovr",   overrun,   1'b0);
        chk("post_rst_perr",  parity_err, 1'b0);
        drain();

`ifdef EDGE_UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_bad_perr",  parity_err, 1'b1);
        chk("par_bad_count", rx_count, 3'd0);
        chk("par_bad_ferr",  frame_err, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_ok_count", rx_count, 3'd1);
        chk("par_ok_data",  rx_data,  8'h07);
        pulse_clear();
        chk("par_clr_perr", parity_err, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_uart_rx_fifo.md
# edge_uart_rx_fifo

UART receive front-end for the SimpleEdgeAiSoC. It sits directly downstream of the `io_uart_rx` pin and feeds the CPU-side UART register block. It:
- Oversamples the asynchronous serial line at 16x and deserialises 8N1 frames.
- Buffers received bytes in a first-word-fall-through FIFO.
- Exposes a valid/ready read port, sticky error flags and a level-triggered `rx_irq`, which drives `io_uart_rx_irq`.

## Interface
Parameters:
- `DIV`, default 54: clock cycles per oversample tick (100 MHz / (115200 × 16)); legal range 2–65535.
- `DEPTH`, default 16: FIFO entries; power of two, 2–256.
- `IRQ_LEVEL`, default 1: `rx_irq` asserts when the FIFO count is ≥ this value; legal range 1–`DEPTH`.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is 1.
- `rx_data`  out  8  FIFO head byte.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; a pop occurs when `rx_valid && rx_ready`.
- `rx_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled as 0.
- `parity_err`  out  1  sticky; parity mismatch. Tied to 0 without the parity macro.
- `clear_err`  in  1  one-cycle pulse that clears all three sticky flags.
- `rx_irq`  out  1  registered; equals `rx_count >= IRQ_LEVEL`.

## Operation
- **Input synchronisation:** `rx` passes through a 2-FF synchroniser. The FSM sees only the synchronised value `rxs`.
- **Tick generator:** a free-running counter counts 0..`DIV`-1 and emits a one-cycle `tick` at `DIV`-1. The counter is cleared when the FSM leaves IDLE, so the first tick is phase-aligned to the start edge.
- **Bit timing:** a 4-bit counter `sc` counts ticks within each bit. The line is sampled at `sc`==7 (mid-bit). A bit ends at `sc`==15.
- **FSM states:**
  - IDLE: when `rxs`==0 → START, with `sc` and the tick counter cleared.
  - START: at the mid-bit sample, if `rxs`==1 it is a false start → IDLE with no flags set. Otherwise, at `sc`==15 → DATA with `bitcnt`=0.
  - DATA: at each mid-bit sample, shift in LSB first. After the 8th bit completes → PARITY if compiled in, else STOP.
  - PARITY: at the mid-bit sample, compare against even parity; if it mismatches, latch a pending-error flag. At bit end → STOP.
  - STOP: at the mid-bit sample:
    - `rxs`==0 → set `frame_err`; discard the byte.
    - `rxs`==1 and parity is bad → set `parity_err`; discard the byte.
    - otherwise → push the byte.
    - In every case the FSM goes to IDLE **at that same sample**. It does not wait for the end of the stop bit, so a back-to-back start bit is caught.
- **FIFO:** circular buffer with read/write pointers of $clog2(DEPTH)+1 bits, wrapping modulo 2×`DEPTH`.
  - Full: `rx_count`==`DEPTH`.
  - Push while full with no pop in the same cycle → the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle while full → both succeed; `rx_count` is unchanged.
  - Push and pop in the same cycle while empty: the push completes first; the pop is not possible because `rx_valid` is 0.
- **Sticky flags:** `clear_err` clears the flags. If `clear_err` coincides with a new error event, the set wins.

## Timing
- **Reset values:**
  - `rx_data` = 0x00.
  - `rx_valid`, `overrun`, `frame_err`, `parity_err` and `rx_irq` = 0.
  - `rx_count` = 0.
  - FSM in IDLE.
  - FIFO pointers = 0.
  - Synchroniser flops = 1.
- **Reset mid-frame:** the partial byte is lost, FIFO contents are discarded, and no flags are set.
- **Start detection:** the FSM enters START 3 cycles after the pin falls (2 synchroniser cycles plus 1 IDLE detect cycle).
- **Receive latency:** `rx_valid` rises 1 cycle after the stop-bit mid-sample. From the falling start edge this is ≈ 3 + (9×16+8)×`DIV` cycles, or +16×`DIV` with parity.
- **Read port:** `rx_data` is valid in the same cycle `rx_valid` is high (FWFT). After a pop, the next head byte is valid on the following cycle.
- **`rx_irq`:** lags `rx_count` by 1 cycle.

## Configuration
- Macro: `EDGE_UART_RX_PARITY_EN`.
- Defined: each frame carries an even-parity bit between D7 and the stop bit. `parity_err` is live and bytes that fail parity are discarded.
- Undefined: the PARITY state and its logic are removed and the frame is plain 8N1. `parity_err` is a constant 0.

## Test plan
All scenarios use `DIV`=4, `DEPTH`=4 and `IRQ_LEVEL`=2 for speed.
- Send 0xA5 as 8N1 with `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, `rx_count`=1, `rx_irq`=0, no error flags.
- Low glitch on `rx` of 6 cycles (less than 8 ticks' worth) → FSM returns to IDLE, `rx_count` stays 0, no error flags.
- Send 0x3C with the stop bit driven to 0 → `frame_err`=1, `rx_count`=0. Then pulse `clear_err` → `frame_err`=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no reads:
  - `rx_count`=4 and `overrun`=1.
  - `rx_irq`=1 from the second byte onward.
  - Draining with `rx_ready`=1 yields 0x01, 0x02, 0x03, 0x04 in order, then `rx_valid`=0.
- Assert `reset` during bit 4 of a frame, then send 0x5A → exactly one byte, 0x5A, is received and all flags are 0.
- With `EDGE_UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong for even parity) → `parity_err`=1 and the byte is dropped. Then send 0x07 with parity bit 1 → the byte is received.
